// File: rtl/vidmode_gen.sv
// Programmable video timing generator.
// Counts pixels and lines for a latched mode. Emits registered sync, valid and
// position outputs one cycle behind the counters. Mode inputs are sampled only
// when leaving IDLE and on the last clock of each frame, so every frame uses one
// consistent timing set.
module vidmode_gen #(
  parameter int BW = 16
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_en,
  input  logic [BW-1:0] i_hm_width,
  input  logic [BW-1:0] i_hm_porch,
  input  logic [BW-1:0] i_hm_synch,
  input  logic [BW-1:0] i_hm_raw,
  input  logic [BW-1:0] i_vm_height,
  input  logic [BW-1:0] i_vm_porch,
  input  logic [BW-1:0] i_vm_synch,
  input  logic [BW-1:0] i_vm_raw,
  output logic          o_pv,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_newline,
  output logic          o_newframe,
  output logic [BW-1:0] o_hpos,
  output logic [BW-1:0] o_vpos,
  output logic          o_active
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [BW-1:0] ONE = {{(BW-1){1'b0}}, 1'b1};

  state_t state, state_nxt;

  // Latched mode, held constant for a whole frame.
  logic [BW-1:0] hwidth, hporch, hsynch, hraw;
  logic [BW-1:0] vheight, vporch, vsynch, vraw;

  // Stage p0: raw position counters.
  logic [BW-1:0] hcount_p0, vcount_p0;

  // Stage p1: registered decode, drives the outputs.
  logic          pv_p1, hsync_p1, vsync_p1, newline_p1, newframe_p1, vld_p1;
  logic [BW-1:0] hpos_p1, vpos_p1;

  logic mode_ok, line_end, frame_end, load_mode, clr_cnt;

  // A timing set is usable when 0 < active <= sync start <= sync end < total.
  function automatic logic mode_valid(input logic [BW-1:0] act,
                                      input logic [BW-1:0] porch,
                                      input logic [BW-1:0] synch,
                                      input logic [BW-1:0] total);
    return (act != '0) && (act <= porch) && (porch <= synch) && (synch < total);
  endfunction

  assign mode_ok   = mode_valid(i_hm_width, i_hm_porch, i_hm_synch, i_hm_raw) &&
                     mode_valid(i_vm_height, i_vm_porch, i_vm_synch, i_vm_raw);
  assign line_end  = (hcount_p0 == hraw - ONE);
  assign frame_end = (state == RUN) && line_end && (vcount_p0 == vraw - ONE);

  // State register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // Next state plus mode-load and counter-clear controls.
  always_comb begin
    state_nxt = state;
    load_mode = 1'b0;
    clr_cnt   = 1'b0;
    case (state)
      IDLE: begin
        if (i_en && mode_ok) begin
          load_mode = 1'b1;
          clr_cnt   = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (frame_end) begin
          clr_cnt = 1'b1;
          if (i_en && mode_ok) load_mode = 1'b1;
          else                 state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Mode latch; only updated when entering RUN or at a frame boundary.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      hwidth  <= '0;
      hporch  <= '0;
      hsynch  <= '0;
      hraw    <= '0;
      vheight <= '0;
      vporch  <= '0;
      vsynch  <= '0;
      vraw    <= '0;
    end else if (load_mode) begin
      hwidth  <= i_hm_width;
      hporch  <= i_hm_porch;
      hsynch  <= i_hm_synch;
      hraw    <= i_hm_raw;
      vheight <= i_vm_height;
      vporch  <= i_vm_porch;
      vsynch  <= i_vm_synch;
      vraw    <= i_vm_raw;
    end
  end

  // Pixel and line counters; the frame-end wrap is handled by the clear.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      hcount_p0 <= '0;
      vcount_p0 <= '0;
    end else if (clr_cnt) begin
      hcount_p0 <= '0;
      vcount_p0 <= '0;
    end else if (state == RUN) begin
      if (line_end) begin
        hcount_p0 <= '0;
        vcount_p0 <= vcount_p0 + ONE;
      end else begin
        hcount_p0 <= hcount_p0 + ONE;
      end
    end
  end

  // Registered decode of the counters; everything is forced low outside RUN.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pv_p1       <= 1'b0;
      hsync_p1    <= 1'b0;
      vsync_p1    <= 1'b0;
      newline_p1  <= 1'b0;
      newframe_p1 <= 1'b0;
      vld_p1      <= 1'b0;
      hpos_p1     <= '0;
      vpos_p1     <= '0;
    end else if (state == RUN) begin
      pv_p1       <= (hcount_p0 < hwidth) && (vcount_p0 < vheight);
      hsync_p1    <= (hcount_p0 >= hporch) && (hcount_p0 < hsynch);
      vsync_p1    <= (vcount_p0 >= vporch) && (vcount_p0 < vsynch);
      newline_p1  <= (hcount_p0 == '0);
      newframe_p1 <= (hcount_p0 == '0) && (vcount_p0 == '0);
      vld_p1      <= 1'b1;
      hpos_p1     <= hcount_p0;
      vpos_p1     <= vcount_p0;
    end else begin
      pv_p1       <= 1'b0;
      hsync_p1    <= 1'b0;
      vsync_p1    <= 1'b0;
      newline_p1  <= 1'b0;
      newframe_p1 <= 1'b0;
      vld_p1      <= 1'b0;
      hpos_p1     <= '0;
      vpos_p1     <= '0;
    end
  end

  assign o_pv       = pv_p1;
  assign o_hsync    = hsync_p1;
  assign o_vsync    = vsync_p1;
  assign o_newline  = newline_p1;
  assign o_newframe = newframe_p1;
  assign o_hpos     = hpos_p1;
  assign o_vpos     = vpos_p1;
  assign o_active   = vld_p1;

endmodule

// File: tb/tb_vidmode_gen.sv
// Directed testbench for vidmode_gen.
module tb_vidmode_gen;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_en;
  logic [15:0] i_hm_width, i_hm_porch, i_hm_synch, i_hm_raw;
  logic [15:0] i_vm_height, i_vm_porch, i_vm_synch, i_vm_raw;
  logic        o_pv, o_hsync, o_vsync, o_newline, o_newframe, o_active;
  logic [15:0] o_hpos, o_vpos;

  int total = 0;
  int bad   = 0;

  vidmode_gen #(.BW(16)) dut (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_en       (i_en),
    .i_hm_width (i_hm_width),
    .i_hm_porch (i_hm_porch),
    .i_hm_synch (i_hm_synch),
    .i_hm_raw   (i_hm_raw),
    .i_vm_height(i_vm_height),
    .i_vm_porch (i_vm_porch),
    .i_vm_synch (i_vm_synch),
    .i_vm_raw   (i_vm_raw),
    .o_pv       (o_pv),
    .o_hsync    (o_hsync),
    .o_vsync    (o_vsync),
    .o_newline  (o_newline),
    .o_newframe (o_newframe),
    .o_hpos     (o_hpos),
    .o_vpos     (o_vpos),
    .o_active   (o_active)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_mode(input int hw, input int hp, input int hs, input int hr,
                          input int vh, input int vp, input int vs, input int vr);
    i_hm_width  = 16'(hw);
    i_hm_porch  = 16'(hp);
    i_hm_synch  = 16'(hs);
    i_hm_raw    = 16'(hr);
    i_vm_height = 16'(vh);
    i_vm_porch  = 16'(vp);
    i_vm_synch  = 16'(vs);
    i_vm_raw    = 16'(vr);
  endtask

  function automatic logic [63:0] all_out();
    return {26'd0, o_pv, o_hsync, o_vsync, o_newline, o_newframe, o_active, o_hpos, o_vpos};
  endfunction

  // Advance at least one clock, then until o_newframe is seen or the budget runs out.
  task automatic wait_newframe(input int budget, output bit ok);
    int n;
    n = 0;
    tick();
    while (!o_newframe && n < budget) begin
      tick();
      n++;
    end
    ok = o_newframe;
  endtask

  // Starting on a newframe sample, count cycles and flags up to the next newframe.
  task automatic measure_frame(output int len, output int npv, output int nhs, output int nvs);
    len = 0; npv = 0; nhs = 0; nvs = 0;
    do begin
      npv += int'(o_pv);
      nhs += int'(o_hsync);
      nvs += int'(o_vsync);
      len++;
      tick();
    end while (!o_newframe && len < 2000);
  endtask

  initial begin
    int  len, npv, nhs, nvs, cnt, lasth, lastv;
    bit  ok;

    // Reset behaviour
    i_reset_n = 1'b1;
    i_en      = 1'b1;
    set_mode(4, 5, 7, 8, 3, 4, 5, 6);
    #1 i_reset_n = 1'b0;
    #1 check("reset_async", all_out(), 64'd0);
    tick();
    check("reset_held", all_out(), 64'd0);
    #2 i_reset_n = 1'b1;
    tick();
    check("run_entry_no_out", all_out(), 64'd0);
    tick();

    // First small frame, cycle by cycle
    for (int i = 0; i < 48; i++) begin
      int h, v;
      h = i % 8;
      v = i / 8;
      check("f1_hpos", o_hpos, h);
      check("f1_vpos", o_vpos, v);
      check("f1_flags", {o_pv, o_hsync, o_vsync, o_newline, o_newframe, o_active},
            {(h < 4) && (v < 3), (h == 5) || (h == 6), v == 4, h == 0, i == 0, 1'b1});
      tick();
    end
    check("f2_newframe", o_newframe, 1'b1);

    // Mode change mid-frame: current frame keeps the old timing
    set_mode(2, 3, 4, 5, 2, 2, 3, 4);
    measure_frame(len, npv, nhs, nvs);
    check("old_len", len, 48);
    check("old_pv", npv, 12);
    check("old_hs", nhs, 12);
    check("old_vs", nvs, 8);
    measure_frame(len, npv, nhs, nvs);
    check("new_len", len, 20);
    check("new_pv", npv, 4);
    check("new_hs", nhs, 4);
    check("new_vs", nvs, 5);

    // Drop enable mid-frame: frame completes, then IDLE
    repeat (3) tick();
    i_en = 1'b0;
    cnt = 0; lasth = -1; lastv = -1;
    while (o_active && cnt < 100) begin
      lasth = int'(o_hpos);
      lastv = int'(o_vpos);
      cnt++;
      tick();
    end
    check("drop_cnt", cnt, 17);
    check("drop_lasth", lasth, 4);
    check("drop_lastv", lastv, 3);
    check("drop_idle", all_out(), 64'd0);
    tick();
    check("drop_idle2", all_out(), 64'd0);

    // Invalid modes from IDLE
    i_en = 1'b1;
    set_mode(4, 3, 7, 8, 3, 4, 5, 6);
    repeat (5) tick();
    check("inv_porch", all_out(), 64'd0);
    set_mode(4, 5, 7, 8, 3, 4, 5, 0);
    repeat (5) tick();
    check("inv_raw0", all_out(), 64'd0);

    // Invalid at frame end: frame completes, then IDLE
    set_mode(4, 5, 7, 8, 3, 4, 5, 6);
    wait_newframe(10, ok);
    check("valid_start", ok, 1'b1);
    i_hm_raw = 16'd0;
    cnt = 0;
    while (o_active && cnt < 200) begin
      cnt++;
      tick();
    end
    check("inv_end_cnt", cnt, 48);
    check("inv_end_idle", all_out(), 64'd0);

    // Reset mid-line between clock edges
    i_hm_raw = 16'd8;
    wait_newframe(10, ok);
    check("rst_pre_start", ok, 1'b1);
    repeat (3) tick();
    #2 i_reset_n = 1'b0;
    #1 check("rst_mid_async", all_out(), 64'd0);
    tick();
    check("rst_mid_held", all_out(), 64'd0);
    #2 i_reset_n = 1'b1;
    tick();
    check("rst_rel_entry", {o_active, o_newframe}, 2'b00);
    tick();
    check("rst_rel_nf", {o_active, o_newframe, o_newline}, 3'b111);
    check("rst_rel_pos", {o_hpos, o_vpos}, 32'd0);

    // Standard 640x480 timing, first line only
    set_mode(640, 656, 752, 800, 480, 490, 492, 525);
    wait_newframe(60, ok);
    check("vga_start", ok, 1'b1);
    npv = 0; nhs = 0;
    for (int i = 0; i < 800; i++) begin
      npv += int'(o_pv);
      nhs += int'(o_hsync);
      tick();
    end
    check("vga_pv", npv, 640);
    check("vga_hs", nhs, 96);
    check("vga_line2", {o_newline, o_newframe}, 2'b10);
    check("vga_pos", {o_hpos, o_vpos}, {16'd0, 16'd1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vidmode_gen.md
VIDMODE_GEN -- requirements
Module: vidmode_gen

Interface
REQ-001 SHALL have parameter BW, default 16, width of all mode and position fields.
REQ-002 SHALL have port i_clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port i_reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port i_en  input  1  run request; sampled only at frame boundaries and in IDLE.
REQ-005 SHALL have ports i_hm_width, i_hm_porch, i_hm_synch, i_hm_raw  input  BW each  horizontal active pixels, sync start, sync end, total clocks per line.
REQ-006 SHALL have ports i_vm_height, i_vm_porch, i_vm_synch, i_vm_raw  input  BW each  vertical active lines, sync start line, sync end line, total lines per frame.
REQ-007 SHALL have port o_pv  output  1  pixel valid (active region).
REQ-008 SHALL have ports o_hsync and o_vsync  output  1 each  active-high sync.
REQ-009 SHALL have ports o_newline and o_newframe  output  1 each  single-cycle strobes at hpos 0, and at hpos 0 with vpos 0.
REQ-010 SHALL have ports o_hpos and o_vpos  output  BW each  current pixel/line position.
REQ-011 SHALL have port o_active  output  1  high while in RUN.

Function
REQ-012 SHALL implement states IDLE and RUN; reset state IDLE.
REQ-013 Mode inputs SHALL be valid when 0<width<=porch<=synch<raw for both H and V sets.
REQ-014 In IDLE, when i_en=1 and inputs are valid, SHALL latch all eight mode inputs, clear both counters and enter RUN on the same edge.
REQ-015 In RUN, hcount SHALL increment each clock, wrap to 0 after latched hraw-1, and vcount SHALL increment on each hcount wrap, wrapping to 0 after latched vraw-1.
REQ-016 Mode inputs SHALL be re-evaluated only on the frame-end clock (hcount=hraw-1, vcount=vraw-1); changes at any other time SHALL be ignored.
REQ-017 At frame end: i_en=1 and inputs valid -> latch new mode and continue with counters 0; i_en=0 or inputs invalid -> go IDLE with counters 0.
REQ-018 Outputs SHALL be registered decodes of (hcount,vcount) with exactly 1 cycle latency; o_hpos/o_vpos SHALL be aligned with the same latency.
REQ-019 o_pv SHALL be 1 iff hpos<hwidth and vpos<vheight.
REQ-020 o_hsync SHALL be 1 iff hporch<=hpos<hsynch, on every line, blanking lines included.
REQ-021 o_vsync SHALL be 1 iff vporch<=vpos<vsynch, for every clock of those lines.
REQ-022 In IDLE, all outputs SHALL be 0 one cycle after entry.
REQ-023 Comparisons SHALL be unsigned BW-bit; counters SHALL never exceed latched raw-1.
REQ-024 Simultaneous frame end and i_en fall SHALL complete the current frame, then enter IDLE; no partial frame SHALL ever be emitted.

Reset
REQ-025 While i_reset_n=0, state SHALL be IDLE, counters and latched mode SHALL be 0, and all outputs SHALL be 0, asynchronously.
REQ-026 Reset asserted mid-frame SHALL abort immediately; after release, behaviour SHALL be as from power-up.
REQ-027 Reset release SHALL take effect synchronously; first possible RUN entry is the first rising edge with i_reset_n=1.

Verification
REQ-028 Small mode H=4/5/7/8, V=3/4/5/6, i_en=1 -> 48-clock frame, 12 o_pv cycles, o_hsync high at hpos 5,6 of all 6 lines, o_vsync high 8 cycles (line 4), o_newframe every 48 clocks.
REQ-029 Mode 640/656/752/800, 480/490/492/525 -> 420000 clocks/frame, 480 lines with o_pv, hsync width 96, vsync lines 490-491.
REQ-030 Change mode inputs mid-frame -> current frame unchanged; new timing starts exactly at next o_newframe.
REQ-031 Drop i_en mid-frame -> frame completes, o_active falls one cycle after frame end, all outputs 0.
REQ-032 Invalid mode (porch<width, or raw=0) with i_en=1 from IDLE -> stays IDLE, outputs 0; invalid at frame end -> IDLE.
REQ-033 Assert i_reset_n=0 mid-line, between clock edges -> outputs 0 immediately; restart after release yields o_newframe one cycle after RUN entry.
